// File: rtl/ksa_pkg.sv
// ksa_pkg: shared sizing helpers for the pipelined Kogge-Stone adder.
// ksa_levels(width) gives the prefix level count clog2(width); ksa_ranks gives the register rank count.
package ksa_pkg;
  function automatic int ksa_levels(input int width);
    return $clog2(width);
  endfunction
  function automatic int ksa_ranks(input int width, input int lvl_per_stg);
    return 1 + (ksa_levels(width) + lvl_per_stg - 1) / lvl_per_stg;
  endfunction
endpackage

// File: rtl/ksa_prefix_level.sv
// ksa_prefix_level: one combinational Kogge-Stone level at distance DIST.
// Ports: p_in/g_in group propagate/generate in, p_out/g_out combined out; positions below DIST pass through.
module ksa_prefix_level
  import ksa_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST = 1
) (
  input  logic [WIDTH-1:0] p_in,
  input  logic [WIDTH-1:0] g_in,
  output logic [WIDTH-1:0] p_out,
  output logic [WIDTH-1:0] g_out
);
  localparam logic [WIDTH-1:0] LOW = {{(WIDTH-DIST){1'b0}}, {DIST{1'b1}}};
  assign g_out = g_in | (p_in & (g_in << DIST));
  assign p_out = p_in & ((p_in << DIST) | LOW);
endmodule

// File: rtl/ks_adder_pipe.sv
// ks_adder_pipe: pipelined Kogge-Stone adder/subtractor with valid/ready handshakes.
// Ports: clk; rst_n async active low; in_valid/in_ready with a, b, ci, sub (1: a + ~b + ci);
// out_valid/out_ready with s, co (true carry), ovf, zero. ovf/zero are built only when KSA_FLAGS_EN is defined.
module ks_adder_pipe
  import ksa_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LVL_PER_STG = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             zero
);
  localparam int L = ksa_levels(WIDTH);
  localparam int R = ksa_ranks(WIDTH, LVL_PER_STG);
  // gx/px are the prefix vectors shifted up one position so ci sits at index 0;
  // after all levels gx[i] is the carry into bit i. gt keeps g of the top bit for co.
  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] gx;
    logic [WIDTH-1:0] px;
    logic             gt;
`ifdef KSA_FLAGS_EN
    logic             sa;
    logic             sb;
`endif
  } rank_t;
  rank_t            q [R-1];
  rank_t            pre;
  logic [R-1:0]     v, ld;
  logic [WIDTH-1:0] bb, sum;
  logic [WIDTH-1:0] gi [L];
  logic [WIDTH-1:0] pi [L];
  logic [WIDTH-1:0] go [L];
  logic [WIDTH-1:0] po [L];
  logic             cout;
  always_comb begin
    bb = sub ? ~b : b;
    pre.p = a ^ bb;
    pre.gt = a[WIDTH-1] & bb[WIDTH-1];
    pre.gx = {a[WIDTH-2:0] & bb[WIDTH-2:0], ci};
    pre.px = {pre.p[WIDTH-2:0], 1'b0};
`ifdef KSA_FLAGS_EN
    pre.sa = a[WIDTH-1];
    pre.sb = bb[WIDTH-1];
`endif
  end
  // A rank loads unless it and every rank after it are full while the consumer stalls.
  for (genvar r = 0; r < R; r++) begin : g_ld
    assign ld[r] = out_ready | ~&v[R-1:r];
  end
  assign in_ready = ld[0];
  assign out_valid = v[R-1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v <= '0;
    else v <= (v & ~ld) | ({v[R-2:0], in_valid} & ld);
  end
  always_ff @(posedge clk) begin
    if (in_valid && ld[0]) q[0] <= pre;
    for (int r = 1; r < R - 1; r++) begin
      if (v[r-1] && ld[r]) begin
        q[r] <= q[r-1];
        q[r].gx <= go[r*LVL_PER_STG-1];
        q[r].px <= po[r*LVL_PER_STG-1];
      end
    end
  end
  for (genvar k = 0; k < L; k++) begin : g_lvl
    if (k % LVL_PER_STG == 0) begin : g_src
      assign gi[k] = q[k/LVL_PER_STG].gx;
      assign pi[k] = q[k/LVL_PER_STG].px;
    end else begin : g_chain
      assign gi[k] = go[k-1];
      assign pi[k] = po[k-1];
    end
    ksa_prefix_level #(.WIDTH(WIDTH), .DIST(1 << k)) u_lvl (
      .p_in(pi[k]),
      .g_in(gi[k]),
      .p_out(po[k]),
      .g_out(go[k])
    );
  end
  assign sum = q[R-2].p ^ go[L-1];
  assign cout = q[R-2].gt | (q[R-2].p[WIDTH-1] & go[L-1][WIDTH-1]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= '0;
      co <= 1'b0;
    end else if (v[R-2] && ld[R-1]) begin
      s <= sum;
      co <= cout;
    end
  end
`ifdef KSA_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      zero <= 1'b0;
    end else if (v[R-2] && ld[R-1]) begin
      ovf <= (q[R-2].sa == q[R-2].sb) && (sum[WIDTH-1] != q[R-2].sa);
      zero <= ~|sum;
    end
  end
`else
  assign ovf = 1'b0;
  assign zero = 1'b0;
`endif
endmodule

// File: tb/tb_ks_adder_pipe.sv
// tb_ks_adder_pipe: scoreboard bench for ks_adder_pipe (32-bit/2 levels per rank, plus 13-bit/1 level per rank).
module tb_ks_adder_pipe;
`ifdef KSA_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif
  typedef struct {logic [31:0] s; logic co, ovf, zero; int t; bit lat;} exp_t;
  typedef struct {logic [12:0] s; logic co, ovf, zero; int t; bit lat;} exp13_t;
  logic clk = 0, rst_n = 0, x_rst_n = 0;
  logic in_valid = 0, in_ready, ci = 0, sub = 0, out_valid, out_ready = 0, co, ovf, zero;
  logic [31:0] a = 0, b = 0, s;
  logic x_in_valid = 0, x_in_ready, x_ci = 0, x_sub = 0, x_out_valid, x_out_ready = 0, x_co, x_ovf, x_zero;
  logic [12:0] x_a = 0, x_b = 0, x_s;
  int cyc = 0, n_chk = 0, n_fail = 0, out_cnt = 0;
  exp_t sb[$];
  exp13_t xq[$];
  exp_t me;
  exp13_t xe;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  ks_adder_pipe #(.WIDTH(32), .LVL_PER_STG(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .ci(ci), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .co(co), .ovf(ovf), .zero(zero)
  );
  ks_adder_pipe #(.WIDTH(13), .LVL_PER_STG(1)) u_aux (
    .clk(clk), .rst_n(x_rst_n), .in_valid(x_in_valid), .in_ready(x_in_ready), .a(x_a), .b(x_b), .ci(x_ci),
    .sub(x_sub), .out_valid(x_out_valid), .out_ready(x_out_ready), .s(x_s), .co(x_co), .ovf(x_ovf), .zero(x_zero)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic exp_t mk(input logic [31:0] s_, input logic co_, ovf_, zero_, input bit lat_);
    exp_t r;
    r.s = s_; r.co = co_; r.ovf = ovf_ & FL; r.zero = zero_ & FL; r.t = 0; r.lat = lat_;
    return r;
  endfunction
  function automatic exp_t m32(input logic [31:0] a_, b_, input logic ci_, sub_);
    logic [31:0] bb_ = sub_ ? ~b_ : b_;
    logic [32:0] r_ = {1'b0, a_} + {1'b0, bb_} + 33'(ci_);
    return mk(r_[31:0], r_[32], (a_[31] == bb_[31]) && (r_[31] != a_[31]), r_[31:0] == 0, 1'b1);
  endfunction
  function automatic exp13_t m13(input logic [12:0] a_, b_, input logic ci_, sub_);
    logic [12:0] bb_ = sub_ ? ~b_ : b_;
    logic [13:0] r_ = {1'b0, a_} + {1'b0, bb_} + 14'(ci_);
    exp13_t r;
    r.s = r_[12:0]; r.co = r_[13]; r.t = 0; r.lat = 0;
    r.ovf = FL & (a_[12] == bb_[12]) & (r_[12] != a_[12]);
    r.zero = FL & (r_[12:0] == 0);
    return r;
  endfunction
  // Called just after a falling edge: presents a beat and records it if it will be taken on the next rising edge.
  task automatic offer(input logic [31:0] a_, b_, input logic ci_, sub_, input exp_t e, output bit took);
    in_valid = 1; a = a_; b = b_; ci = ci_; sub = sub_;
    #1;
    took = in_ready;
    if (took) begin
      e.t = cyc;
      sb.push_back(e);
    end
  endtask
  task automatic send(input logic [31:0] a_, b_, input logic ci_, sub_, input exp_t e);
    bit took = 0;
    for (int n = 0; n < 50 && !took; n++) begin
      @(negedge clk);
      offer(a_, b_, ci_, sub_, e, took);
    end
    chk("send_accepted", took, 1);
  endtask
  task automatic drain();
    @(negedge clk);
    in_valid = 0;
    for (int n = 0; n < 60 && sb.size() != 0; n++) begin
      @(negedge clk);
      #3;
    end
    chk("drain_empty", sb.size(), 0);
  endtask
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid) begin
      if (sb.size() == 0) chk("unexpected_out", out_valid, 0);
      else begin
        me = sb[0];
        chk("sum", s, me.s);
        chk("carry", co, me.co);
        chk("ovf", ovf, me.ovf);
        chk("zero", zero, me.zero);
        if (out_ready) begin
          if (me.lat) chk("latency", cyc - me.t, 4);
          void'(sb.pop_front());
          out_cnt++;
        end
      end
    end
  end
  always @(negedge clk) begin
    #2;
    if (x_rst_n && x_out_valid) begin
      if (xq.size() == 0) chk("aux_unexpected_out", x_out_valid, 0);
      else begin
        xe = xq[0];
        chk("aux_co_sum", {x_co, x_s}, {xe.co, xe.s});
        chk("aux_flags", {x_ovf, x_zero}, {xe.ovf, xe.zero});
        if (x_out_ready) begin
          if (xe.lat) chk("aux_latency", cyc - xe.t, 5);
          void'(xq.pop_front());
        end
      end
    end
  end
  task automatic main_seq();
    int idx, drops, base;
    bit took;
    logic [31:0] ta, tb;
    @(negedge clk);
    out_ready = 1;
    send(32'hFFFF_FFFF, 32'h0, 1, 0, mk(32'h0, 1, 0, 1, 1));
    send(32'h5, 32'h7, 1, 1, mk(32'hFFFF_FFFE, 0, 0, 0, 1));
    send(32'h8000_0000, 32'h1, 1, 1, mk(32'h7FFF_FFFF, 1, 1, 0, 1));
    send(32'h7FFF_FFFF, 32'h1, 0, 0, mk(32'h8000_0000, 0, 1, 0, 1));
    send(32'h1234_5678, 32'h9ABC_DEF0, 0, 0, mk(32'hACF1_3568, 0, 0, 0, 1));
    send(32'h0, 32'h0, 1, 1, mk(32'h0, 1, 0, 1, 1));
    send(32'h3, 32'h3, 0, 1, mk(32'hFFFF_FFFF, 0, 0, 0, 1));
    drain();
    idx = 0;
    for (int t = 0; t < 60 && idx < 10; t++) begin
      @(negedge clk);
      out_ready = !(t >= 3 && t <= 9);
      offer(32'(idx), 32'(idx), 0, 0, mk(32'(2 * idx), 0, 0, idx == 0, 0), took);
      if (took) idx++;
      if (t == 9) begin
        chk("bp_in_ready_full", in_ready, 0);
        chk("bp_out_valid_held", out_valid, 1);
      end
      if (t == 10) chk("bp_in_ready_release", in_ready, 1);
    end
    chk("bp_beats", idx, 10);
    out_ready = 1;
    drain();
    for (int i = 0; i < 3; i++) send(32'(100 + i), 32'h5, 0, 0, mk(32'(105 + i), 0, 0, 0, 0));
    @(negedge clk);
    in_valid = 0;
    rst_n = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", s, 0);
    chk("rst_co", co, 0);
    chk("rst_in_ready", in_ready, 1);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #3;
      chk("no_stale_out", out_valid, 0);
    end
    send(32'h1, 32'h2, 0, 0, mk(32'h3, 0, 0, 0, 1));
    drain();
    base = out_cnt;
    drops = 0;
    for (int i = 0; i < 100; i++) begin
      ta = 32'(i) * 32'h0101_0101;
      tb = 32'h0F0F_0F0F ^ 32'(i);
      @(negedge clk);
      offer(ta, tb, i[0], i[1], m32(ta, tb, i[0], i[1]), took);
      if (!took) drops++;
    end
    drain();
    chk("tput_drops", drops, 0);
    chk("tput_results", out_cnt - base, 100);
  endtask
  task automatic aux_seq();
    int got = 0;
    bit pend = 0;
    exp13_t e;
    for (int c = 0; c < 60000 && got < 10000; c++) begin
      @(negedge clk);
      x_out_ready = ($urandom_range(0, 3) != 0);
      if (!pend) begin
        x_in_valid = ($urandom_range(0, 3) != 0);
        x_a = 13'($urandom());
        x_b = 13'($urandom());
        x_ci = 1'($urandom());
        x_sub = 1'($urandom());
      end
      #1;
      if (x_in_valid && x_in_ready) begin
        e = m13(x_a, x_b, x_ci, x_sub);
        e.t = cyc;
        xq.push_back(e);
        got++;
        pend = 0;
      end else pend = x_in_valid;
    end
    chk("aux_beats", got, 10000);
    @(negedge clk);
    x_in_valid = 0;
    x_out_ready = 1;
    for (int c = 0; c < 40 && xq.size() != 0; c++) begin
      @(negedge clk);
      #3;
    end
    chk("aux_drain", xq.size(), 0);
    @(negedge clk);
    x_a = 13'h1FFF; x_b = 13'h1; x_ci = 0; x_sub = 0; x_in_valid = 1;
    #1;
    chk("aux_ready_idle", x_in_ready, 1);
    if (x_in_ready) begin
      e = m13(x_a, x_b, x_ci, x_sub);
      e.t = cyc;
      e.lat = 1;
      xq.push_back(e);
    end
    @(negedge clk);
    x_in_valid = 0;
    for (int c = 0; c < 40 && xq.size() != 0; c++) begin
      @(negedge clk);
      #3;
    end
    chk("aux_latency_drain", xq.size(), 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_sum", s, 0);
    chk("reset_co", co, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_zero", zero, 0);
    chk("reset_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1;
    x_rst_n = 1;
    fork
      main_seq();
      aux_seq();
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time got %0t expected completion before it", $time);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/ks_adder_pipe.md
# ks_adder_pipe

Parametrised, pipelined Kogge-Stone adder/subtractor with valid/ready handshakes on input and output. It is the successor to the team's fixed 32-bit combinational Kogge-Stone adder. Width, prefix levels per pipeline stage and add/subtract mode are selectable. Datapath blocks use it wherever a wide add must close timing at full clock rate under backpressure.

## Interface
- WIDTH, 32: operand width; ≥ 2, any value; prefix levels L = clog2(WIDTH)
- LVL_PER_STG, 2: prefix levels evaluated between register ranks; 1..L
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- ci  in  1  carry-in
- sub  in  1  1: compute a + ~b + ci; 0: a + b + ci
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- s  out  WIDTH  sum
- co  out  1  carry-out (true carry, not borrow)
- ovf  out  1  signed overflow (KSA_FLAGS_EN)
- zero  out  1  s == 0 (KSA_FLAGS_EN)

## Operation
- Beat accepted when in_valid && in_ready. The operands, ci and sub are captured together.
- Pre-process: bb = sub ? ~b : b; p = a ^ bb; g = a & bb. The carry-in is folded in as generate bit position -1, as in the 32-bit adder.
- Prefix level k (k = 0..L-1), distance 2^k:
  - G[i] = G[i] | P[i] & G[i-2^k]; P[i] = P[i] & P[i-2^k] for i ≥ 2^k.
  - Lower positions pass through.
- Sum: s[i] = p[i] ^ Gc[i-1], where Gc[-1] = ci. co = final group carry into position WIDTH.
- Results emerge in acceptance order; no reordering, no drops, no duplicates.
- Ranks: R = 1 + ceil(L / LVL_PER_STG).
  - Rank 0 holds p, g, ci and sign bits.
  - Ranks 1..R-2 each follow LVL_PER_STG levels.
  - Rank R-1 (output) follows the remaining levels plus the sum.
- Each rank has a valid bit. Rank r loads when it is empty or rank r+1 loads. The output rank loads when empty or out_ready=1.
- in_ready = rank 0 loads. It is combinational from out_ready through the ready chain; there is no combinational path from in_valid.
- Bubbles collapse: an empty rank accepts even if downstream ranks are stalled.

## Timing
- Latency: R cycles from accept edge to out_valid, when not stalled.
  - WIDTH=32, LVL_PER_STG=2: R=4.
  - WIDTH=8, LVL_PER_STG=3: R=2.
- Throughput: one beat per cycle with out_ready held high.
- Stall: out_valid=1 && out_ready=0 holds s/co/flags stable. Upstream ranks keep filling until all R ranks are full, then in_ready=0.
- Simultaneous out_ready=1 and a full pipe: in_ready=1 in the same cycle; no bubble is inserted.
- Reset: all valid bits 0, s=0, co=0, ovf=0, zero=0.
  - in_ready=1 during reset.
  - Reset mid-operation discards all in-flight beats. The first out_valid after reset belongs to a beat accepted after reset.
- The data registers of non-output ranks need no reset. Only valid bits and output registers reset.

## Configuration
- KSA_FLAGS_EN defined:
  - ovf = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]). Both operand sign bits travel through the ranks.
  - zero = ~|s.
  - Both flags are registered with s.
- Not defined: ovf and zero are tied 0. No sign bits are carried and no zero-detect logic is built. The port list is unchanged.

## Structure
- Package ksa_pkg holds:
  - function ksa_levels(width), returning clog2
  - function ksa_ranks(width, lvl_per_stg), returning R
  - typedef of per-rank bundle {valid, p, g, ci, sa, sb}
- Sub-module ksa_prefix_level, parameters WIDTH and DIST: one combinational Kogge-Stone level, (P,G) in to (P,G) out. It is instantiated L times via generate. Register ranks are inserted between instances where (k+1) % LVL_PER_STG == 0.

## Test plan
- WIDTH=32, LVL_PER_STG=2, sub=0: a=32'hFFFF_FFFF, b=0, ci=1 -> s=0, co=1, zero=1, out_valid exactly 4 cycles after accept.
- sub=1, ci=1: a=5, b=7 -> s=32'hFFFF_FFFE, co=0. a=32'h8000_0000, b=1 -> s=32'h7FFF_FFFF, ovf=1 (KSA_FLAGS_EN).
- Backpressure: stream 10 beats (a=i, b=i, ci=0) with out_ready low for cycles 3-9. Require in_ready=0 after 4 beats are held, then in-order results s=2i with no loss or duplicates.
- Assert rst_n low with 3 beats in flight -> out_valid=0 and s=0 immediately. No stale result after release; next accepted a=1, b=2 gives s=3.
- WIDTH=13, LVL_PER_STG=1 (L=4, R=5): random 10k beats with random out_ready vs reference model. All {co,s} match; latency is 5 when unstalled.
- Full-throughput: out_ready=1 and in_valid=1 continuous for 100 cycles -> in_ready never drops, one result per cycle.
